accel_ctrl_regs: RTL and testbench
==================================

# accel_ctrl_regs

Parametrised AXI4-Lite control/status register file for accelerator cores; successor to the fixed core-control memory map. Provides a configurable bank of software read/write control registers, a bank of hardware-driven read-only status registers, and a sticky, maskable interrupt pair. It sits between the host AXI-Lite interconnect and the accelerator core. It adds full AXI-Lite handshakes, byte strobes, error responses, and per-register write pulses.

## Interface
- DATA_W, 32, register and AXI data width; multiple of 8.
- ADDR_W, 8, AXI byte-address width; word index = addr[ADDR_W-1:2].
- N_RW, 8, number of read/write control registers, indices 0..N_RW-1.
- N_RO, 8, number of read-only status registers, indices N_RW..N_RW+N_RO-1.
- N_IRQ, 4, number of interrupt sources; N_IRQ ≤ DATA_W.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous assert, active-low.
- awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write-address channel.
- wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/DATA_W/8/1/1  write-data channel.
- bresp/bvalid/bready  out/out/in  2/1/1  write-response channel.
- araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read-address channel.
- rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  read-data channel.
- ctrl_o  out  N_RW*DATA_W  flattened RW register contents; register i occupies bits [i*DATA_W +: DATA_W].
- wr_pulse_o  out  N_RW  one-cycle pulse when software writes RW register i.
- status_i  in  N_RO*DATA_W  core status words; must be synchronous to aclk.
- irq_event_i  in  N_IRQ  single-cycle interrupt source events.
- irq_o  out  1  level interrupt, registered.

## Operation
Address map (word index):
- RW registers occupy indices 0..N_RW-1.
- RO registers occupy the next N_RO indices; reads return status_i directly.
- IRQ_STATUS is at index N_RW+N_RO; it is W1C.
- IRQ_ENABLE is at index N_RW+N_RO+1; it is RW, with the low N_IRQ bits implemented.
- Any higher index is out of range.

Writes:
- Apply to RW and IRQ_ENABLE registers per byte, under wstrb.
- Return OKAY (2'b00).
- Pulse wr_pulse_o[i] regardless of wstrb value.
- Writes to RO registers or out-of-range indices change nothing and return SLVERR (2'b10).

Reads:
- Implemented indices return the register value with OKAY.
- Out-of-range indices return rdata=0 with SLVERR.
- Unimplemented IRQ bits read 0.

IRQ behaviour:
- irq_event_i[j] sets IRQ_STATUS[j].
- A software write with bit j = 1 (strobed byte) clears it.
- If a set and a clear land on the same cycle, the set wins.
- irq_o <= |(IRQ_STATUS & IRQ_ENABLE).

Write FSM (W_IDLE, W_RESP):
- AW and W are accepted independently and latched into aw_held and w_held.
- In W_IDLE: awready = !aw_held and wready = !w_held.
- The write commits on the edge where both halves are available, whether already held or handshaking on that edge. That edge sets bvalid, clears both held flags, and moves to W_RESP.
- In W_RESP: awready = wready = 0. bvalid and bresp hold until bready; on bready, return to W_IDLE.

Read FSM (R_IDLE, R_DATA):
- arready = 1 in R_IDLE.
- On the AR handshake edge: rdata and rresp are registered, rvalid = 1, and the FSM moves to R_DATA.
- rdata, rresp and rvalid hold until rready, then the FSM returns to R_IDLE.
- The read and write paths are fully independent.

## Timing
Reset (async, aresetn=0) drives these outputs immediately:
- awready, wready, arready = 0.
- bvalid, rvalid = 0; bresp, rresp = 0; rdata = 0.
- All registers, including IRQ_STATUS and IRQ_ENABLE, = 0.
- wr_pulse_o = 0; irq_o = 0.

After reset:
- The first edge after deassertion enters W_IDLE and R_IDLE; ready outputs go to 1 on that edge.
- In-flight transactions are dropped; no response is issued for them.

Latencies:
- Write: ctrl_o updates and bvalid rises on the commit edge. wr_pulse_o is high for exactly the cycle after the commit edge.
- Back-to-back writes: each takes a minimum of 2 cycles when bready is held at 1.
- Read: rvalid is high in the cycle after the AR handshake. Status is sampled on the handshake edge.
- IRQ: an event at edge k sets IRQ_STATUS at k; irq_o rises at k+1.

## Structure
- Package accel_ctrl_pkg holds:
  - resp_t: OKAY = 2'b00, SLVERR = 2'b10.
  - wr_state_t and rd_state_t.
  - Address-decode helper functions: index-kind enum with values RW, RO, IRQ_STAT, IRQ_EN, INVALID.
- Sub-module accel_ctrl_irq (N_IRQ) contains the sticky status, enable, W1C/set priority and registered irq_o. The top instantiates it once.

## Test plan
- Reset, then AW and W in the same cycle: addr 0x04, wdata 0xDEADBEEF, wstrb 0xF.
  - Expect bvalid the next cycle with bresp=00, ctrl_o reg1=0xDEADBEEF, and wr_pulse_o=0b10 for 1 cycle.
- W issued 3 cycles before AW: addr 0x00, wstrb 0x3, wdata 0x12345678 over the old value 0xFFFFFFFF.
  - Expect reg0=0xFFFF5678, with wready=0 while W is held.
- Read RO index N_RW with status_i word 0 = 0xA5A5A5A5 and rready held low for 4 cycles.
  - Expect rdata held at 0xA5A5A5A5 with rvalid=1 until rready; arready=0 meanwhile.
- Write and read index 0x3F (out of range).
  - Expect SLVERR on both, rdata=0, and no register change.
- IRQ sequence: enable = 0x1; irq_event_i[0] pulses; expect irq_o=1 one cycle later.
  - W1C 0x1 on the same cycle as a new event: status stays 1.
  - A later W1C alone: irq_o=0.
- Assert aresetn=0 mid-cycle while bvalid=1 and bready=0.
  - Expect bvalid and all registers 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/accel_ctrl_pkg.sv
// Shared types and address-decode helpers for the accelerator control
// register file.
package accel_ctrl_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_RST,
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_RST,
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [2:0] {
        RW,
        RO,
        IRQ_STAT,
        IRQ_EN,
        INVALID
    } idx_kind_t;

    // Map a word index onto the register kind it addresses.
    function automatic idx_kind_t decode_idx(input int unsigned idx,
                                             input int unsigned n_rw,
                                             input int unsigned n_ro);
        idx_kind_t kind;
        if (idx < n_rw)                   kind = RW;
        else if (idx < n_rw + n_ro)       kind = RO;
        else if (idx == n_rw + n_ro)      kind = IRQ_STAT;
        else if (idx == n_rw + n_ro + 1)  kind = IRQ_EN;
        else                              kind = INVALID;
        return kind;
    endfunction

    function automatic resp_t wr_resp(input idx_kind_t kind);
        return (kind == RO || kind == INVALID) ? SLVERR : OKAY;
    endfunction

    function automatic resp_t rd_resp(input idx_kind_t kind);
        return (kind == INVALID) ? SLVERR : OKAY;
    endfunction

endpackage

// File: rtl/accel_ctrl_irq.sv
// Sticky, maskable interrupt block.
// Ports: aclk/aresetn clock and async active-low reset; event_i sets status
// bits; clr_i clears status bits (set wins on the same cycle); en_we_i with
// en_mask_i/en_wdata_i writes the enable bits; status_o/enable_o read back;
// irq_o is the registered OR of enabled pending bits.
module accel_ctrl_irq #(
    parameter int N_IRQ = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [N_IRQ-1:0] event_i,
    input  logic [N_IRQ-1:0] clr_i,
    input  logic             en_we_i,
    input  logic [N_IRQ-1:0] en_mask_i,
    input  logic [N_IRQ-1:0] en_wdata_i,
    output logic [N_IRQ-1:0] status_o,
    output logic [N_IRQ-1:0] enable_o,
    output logic             irq_o
);

    logic [N_IRQ-1:0] status_q, status_d;
    logic [N_IRQ-1:0] enable_q, enable_d;
    logic             irq_q, irq_d;

    always_comb begin
        // OR-ing the event in after the clear lets a simultaneous set win.
        status_d = (status_q & ~clr_i) | event_i;
        enable_d = enable_q;
        if (en_we_i) begin
            enable_d = (enable_q & ~en_mask_i) | (en_wdata_i & en_mask_i);
        end
        irq_d = |(status_q & enable_q);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            status_q <= '0;
            enable_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            enable_q <= enable_d;
            irq_q    <= irq_d;
        end
    end

    assign status_o = status_q;
    assign enable_o = enable_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/accel_ctrl_regs.sv
// AXI4-Lite control/status register file for an accelerator core.
// Ports: aclk/aresetn clock and async active-low reset; AXI-Lite AW/W/B and
// AR/R channels; ctrl_o flattened RW registers; wr_pulse_o per-register
// write strobe; status_i core status words; irq_event_i interrupt sources;
// irq_o level interrupt.
//
// state  | meaning
// W_RST  | out of reset, readies low for one edge
// W_IDLE | collecting AW and W, commit when both present
// W_RESP | response pending until bready
// R_RST  | out of reset, arready low for one edge
// R_IDLE | arready high, waiting for AR
// R_DATA | read data held until rready
module accel_ctrl_regs
    import accel_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int N_RW   = 8,
    parameter int N_RO   = 8,
    parameter int N_IRQ  = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [ADDR_W-1:0]        awaddr,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [ADDR_W-1:0]        araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DATA_W-1:0]        rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [N_RW*DATA_W-1:0]   ctrl_o,
    output logic [N_RW-1:0]          wr_pulse_o,
    input  logic [N_RO*DATA_W-1:0]   status_i,
    input  logic [N_IRQ-1:0]         irq_event_i,
    output logic                     irq_o
);

    localparam int NB = DATA_W / 8;
    localparam int IW = ADDR_W - 2;

    wr_state_t                   wr_state_q, wr_state_d;
    logic                        aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IW-1:0]               awidx_q, awidx_d;
    logic [DATA_W-1:0]           wdata_q, wdata_d;
    logic [NB-1:0]               wstrb_q, wstrb_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic [N_RW-1:0]             wr_pulse_q, wr_pulse_d;
    logic [N_RW-1:0][DATA_W-1:0] ctrl_q, ctrl_d;

    rd_state_t                   rd_state_q, rd_state_d;
    logic [DATA_W-1:0]           rdata_q, rdata_d;
    logic [1:0]                  rresp_q, rresp_d;

    logic                        aw_hs, w_hs, commit;
    logic [DATA_W-1:0]           wr_data;
    logic [NB-1:0]               wr_strb;
    logic [31:0]                 wr_idx, rd_idx;
    idx_kind_t                   wr_kind, rd_kind;
    logic [DATA_W-1:0]           rd_word;
    logic [N_IRQ-1:0]            irq_clr, irq_en_mask, irq_status, irq_enable;
    logic                        irq_en_we;
    logic                        unused_addr_lsbs;

    assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

    assign awready = (wr_state_q == W_IDLE) && !aw_held_q;
    assign wready  = (wr_state_q == W_IDLE) && !w_held_q;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    // Commit on the edge where each half is either already held or
    // handshaking right now.
    assign commit  = (wr_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign wr_idx  = 32'(aw_held_q ? awidx_q : awaddr[ADDR_W-1:2]);
    assign wr_data = w_held_q ? wdata_q : wdata;
    assign wr_strb = w_held_q ? wstrb_q : wstrb;
    assign wr_kind = decode_idx(wr_idx, N_RW, N_RO);

    always_comb begin
        irq_en_mask = '0;
        for (int j = 0; j < N_IRQ; j++) begin
            irq_en_mask[j] = wr_strb[j/8];
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awidx_d    = awidx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        ctrl_d     = ctrl_q;
        wr_pulse_d = '0;
        irq_clr    = '0;
        irq_en_we  = 1'b0;
        case (wr_state_q)
            W_RST: wr_state_d = W_IDLE;
            W_IDLE: begin
                if (commit) begin
                    wr_state_d = W_RESP;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    bresp_d    = wr_resp(wr_kind);
                    if (wr_kind == RW) begin
                        for (int i = 0; i < N_RW; i++) begin
                            if (wr_idx == i) begin
                                wr_pulse_d[i] = 1'b1;
                                for (int b = 0; b < NB; b++) begin
                                    if (wr_strb[b]) ctrl_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
                                end
                            end
                        end
                    end
                    if (wr_kind == IRQ_STAT) irq_clr = wr_data[N_IRQ-1:0] & irq_en_mask;
                    irq_en_we = (wr_kind == IRQ_EN);
                end else begin
                    if (aw_hs) begin
                        aw_held_d = 1'b1;
                        awidx_d   = awaddr[ADDR_W-1:2];
                    end
                    if (w_hs) begin
                        w_held_d = 1'b1;
                        wdata_d  = wdata;
                        wstrb_d  = wstrb;
                    end
                end
            end
            W_RESP: if (bready) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign rd_idx  = 32'(araddr[ADDR_W-1:2]);
    assign rd_kind = decode_idx(rd_idx, N_RW, N_RO);

    always_comb begin
        rd_word = '0;
        case (rd_kind)
            RW: for (int i = 0; i < N_RW; i++) begin
                if (rd_idx == i) rd_word = ctrl_q[i];
            end
            RO: for (int i = 0; i < N_RO; i++) begin
                if (rd_idx == N_RW + i) rd_word = status_i[i*DATA_W +: DATA_W];
            end
            IRQ_STAT: rd_word[N_IRQ-1:0] = irq_status;
            IRQ_EN:   rd_word[N_IRQ-1:0] = irq_enable;
            default:  rd_word = '0;
        endcase
    end

    assign arready = (rd_state_q == R_IDLE);

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_RST: rd_state_d = R_IDLE;
            R_IDLE: if (arvalid) begin
                rd_state_d = R_DATA;
                rdata_d    = rd_word;
                rresp_d    = rd_resp(rd_kind);
            end
            R_DATA: if (rready) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= W_RST;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= '0;
            wr_pulse_q <= '0;
            ctrl_q     <= '0;
            rd_state_q <= R_RST;
            rdata_q    <= '0;
            rresp_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            ctrl_q     <= ctrl_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    accel_ctrl_irq #(.N_IRQ(N_IRQ)) u_irq (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .event_i    (irq_event_i),
        .clr_i      (irq_clr),
        .en_we_i    (irq_en_we),
        .en_mask_i  (irq_en_mask),
        .en_wdata_i (wr_data[N_IRQ-1:0]),
        .status_o   (irq_status),
        .enable_o   (irq_enable),
        .irq_o      (irq_o)
    );

    assign bvalid     = (wr_state_q == W_RESP);
    assign bresp      = bresp_q;
    assign rvalid     = (rd_state_q == R_DATA);
    assign rdata      = rdata_q;
    assign rresp      = rresp_q;
    assign ctrl_o     = ctrl_q;
    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_accel_ctrl_regs.sv
module tb_accel_ctrl_regs;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [7:0]   awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [7:0]   araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [255:0] ctrl_o;
    logic [7:0]   wr_pulse_o;
    logic [255:0] status_i;
    logic [3:0]   irq_event_i;
    logic         irq_o;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents as software would see them.
    logic [31:0] m_ctrl [8];
    logic [31:0] st [8];
    logic [3:0]  m_ist;
    logic [3:0]  m_ien;

    always #5 aclk = ~aclk;

    always_comb begin
        status_i = '0;
        for (int i = 0; i < 8; i++) status_i[i*32 +: 32] = st[i];
    end

    accel_ctrl_regs dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .ctrl_o(ctrl_o), .wr_pulse_o(wr_pulse_o), .status_i(status_i),
        .irq_event_i(irq_event_i), .irq_o(irq_o)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] m_read(input int idx);
        if (idx < 8)        return m_ctrl[idx];
        else if (idx < 16)  return st[idx-8];
        else if (idx == 16) return {28'd0, m_ist};
        else if (idx == 17) return {28'd0, m_ien};
        return 32'd0;
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_ctrl%0d", tag, i), ctrl_o[i*32 +: 32], m_ctrl[i]);
    endtask

    // w_lead > 0: W goes out that many cycles before AW; < 0: AW leads.
    // evt is pulsed on the first edge, which is the commit edge when w_lead == 0.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input logic [3:0] evt);
        int aw_at, w_at, cyc, idx;
        bit aw_done, w_done, got_b, hs_aw, hs_w;
        logic [1:0] exp_resp;
        logic [7:0] exp_pulse;
        aw_at = (w_lead > 0) ? w_lead : 0;
        w_at  = (w_lead < 0) ? -w_lead : 0;
        idx   = int'(addr >> 2);
        exp_resp  = 2'b00;
        exp_pulse = 8'd0;
        if (idx < 8) begin
            exp_pulse[idx] = 1'b1;
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_ctrl[idx][b*8 +: 8] = data[b*8 +: 8];
        end else if (idx < 16) begin
            exp_resp = 2'b10;
        end else if (idx == 16) begin
            if (strb[0]) m_ist = m_ist & ~data[3:0];
        end else if (idx == 17) begin
            if (strb[0]) m_ien = data[3:0];
        end else begin
            exp_resp = 2'b10;
        end
        m_ist = m_ist | evt;

        aw_done = 0; w_done = 0; got_b = 0; cyc = 0;
        bready = 1'b1;
        irq_event_i = evt;
        while (!got_b && cyc < 40) begin
            awaddr  = addr;
            awvalid = !aw_done && (cyc >= aw_at);
            wdata   = data;
            wstrb   = strb;
            wvalid  = !w_done && (cyc >= w_at);
            if (w_done && !aw_done) chk("wready_while_w_held", wready, 1'b0);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            tick();
            irq_event_i = 4'd0;
            aw_done = aw_done || hs_aw;
            w_done  = w_done || hs_w;
            cyc++;
            got_b = bvalid;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("bvalid_seen", got_b, 1'b1);
        chk("bresp", bresp, exp_resp);
        check_regs("wr");
        chk("wr_pulse", wr_pulse_o, exp_pulse);
        tick();
        chk("wr_pulse_gone", wr_pulse_o, 8'd0);
        chk("bvalid_gone", bvalid, 1'b0);
        chk("irq_o_after_wr", irq_o, |(m_ist & m_ien));
    endtask

    task automatic do_read(input logic [7:0] addr, input int hold);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int idx;
        idx      = int'(addr >> 2);
        exp_data = m_read(idx);
        exp_resp = (idx <= 17) ? 2'b00 : 2'b10;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b0;
        chk("arready_idle", arready, 1'b1);
        tick();
        arvalid = 1'b0;
        // Status moves after the handshake; the returned word must not.
        st[$urandom_range(0, 7)] = $urandom;
        for (int i = 0; i <= hold; i++) begin
            chk("rvalid", rvalid, 1'b1);
            chk("rdata", rdata, exp_data);
            chk("rresp", rresp, exp_resp);
            chk("arready_busy", arready, 1'b0);
            if (i == hold) rready = 1'b1;
            tick();
        end
        rready = 1'b0;
        chk("rvalid_gone", rvalid, 1'b0);
    endtask

    initial begin
        int idx, lead;
        logic [3:0] evt;
        aresetn = 1'b0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 1;
        araddr = '0; arvalid = 0; rready = 0; irq_event_i = '0;
        for (int i = 0; i < 8; i++) begin m_ctrl[i] = '0; st[i] = '0; end
        m_ist = '0; m_ien = '0;

        #1;
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ctrl", ctrl_o[63:0], 64'd0);
        chk("rst_irq", irq_o, 1'b0);
        tick(); tick();
        aresetn = 1'b1;
        chk("pre_edge_awready", awready, 1'b0);
        tick();
        chk("post_awready", awready, 1'b1);
        chk("post_wready", wready, 1'b1);
        chk("post_arready", arready, 1'b1);

        // Same-cycle AW and W.
        do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 4'd0);
        chk("reg1_const", ctrl_o[63:32], 32'hDEADBEEF);

        // W leads AW by 3 cycles, partial strobe.
        do_write(8'h00, 32'hFFFFFFFF, 4'hF, 0, 4'd0);
        do_write(8'h00, 32'h12345678, 4'h3, 3, 4'd0);
        chk("reg0_merge", ctrl_o[31:0], 32'hFFFF5678);

        // RO read with rready held off.
        st[0] = 32'hA5A5A5A5;
        do_read(8'h20, 4);

        // Out of range.
        do_write(8'hFC, 32'hCAFEF00D, 4'hF, 0, 4'd0);
        do_read(8'hFC, 1);

        // Interrupt sequence.
        do_write(8'h44, 32'h1, 4'h1, 0, 4'd0);
        irq_event_i = 4'h1;
        tick();
        irq_event_i = 4'h0;
        m_ist = m_ist | 4'h1;
        chk("irq_not_yet", irq_o, 1'b0);
        tick();
        chk("irq_rise", irq_o, 1'b1);
        do_write(8'h40, 32'h1, 4'h1, 0, 4'h1);
        chk("irq_set_wins", irq_o, 1'b1);
        do_read(8'h40, 0);
        do_write(8'h40, 32'h1, 4'h1, 0, 4'd0);
        chk("irq_cleared", irq_o, 1'b0);

        // Randomized mix against the model.
        for (int n = 0; n < 40; n++) begin
            idx = int'($urandom_range(0, 20));
            if (idx == 20) idx = 63;
            if ($urandom_range(0, 1) == 1) begin
                lead = int'($urandom_range(0, 6)) - 3;
                evt  = (lead == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
                do_write(8'(idx << 2), $urandom, 4'($urandom_range(0, 15)), lead, evt);
            end else begin
                st[$urandom_range(0, 7)] = $urandom;
                do_read(8'(idx << 2), int'($urandom_range(0, 3)));
            end
        end

        // Async reset with a response outstanding.
        awaddr = 8'h08; wdata = 32'h55; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; bready = 0;
        tick();
        awvalid = 0; wvalid = 0;
        chk("pend_bvalid", bvalid, 1'b1);
        chk("pend_reg2", ctrl_o[95:64], 32'h55);
        tick();
        chk("pend_bvalid_hold", bvalid, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) m_ctrl[i] = '0;
        m_ist = '0; m_ien = '0;
        chk("async_bvalid", bvalid, 1'b0);
        chk("async_awready", awready, 1'b0);
        chk("async_irq", irq_o, 1'b0);
        check_regs("async");
        tick();
        aresetn = 1'b1;
        bready = 1'b1;
        tick();
        chk("rerun_awready", awready, 1'b1);
        chk("rerun_bvalid", bvalid, 1'b0);
        do_read(8'h44, 0);
        do_write(8'h1C, 32'h0BADC0DE, 4'hC, -2, 4'd0);
        do_read(8'h1C, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
